fetch_queue: RTL and testbench
==============================

# fetch_queue

Decoupling FIFO between the fetch stage (PC register plus instruction memory read) and the decode/rename stage of the out-of-order core. It holds fetched {pc, instruction} pairs so that rename/dispatch stalls (ROB, LSQ or free-list full) do not stall the PC. The same queue discards all wrong-path instructions on a pipeline flush (branch mispredict or exception redirect).

## Interface
- DEPTH, 8: number of entries; power of two, minimum 2.
- XLEN, 32: PC and instruction width.

- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous flush; discards all entries this cycle.
- fetch_valid_in  in  1  fetch presents an instruction.
- fetch_ready_out  out  1  queue accepts an instruction this cycle.
- fetch_pc_in  in  XLEN  PC of the presented instruction.
- fetch_instr_in  in  XLEN  raw instruction word.
- decode_valid_out  out  1  head entry is valid.
- decode_ready_in  in  1  decode consumes the head this cycle.
- decode_pc_out  out  XLEN  PC of the head entry.
- decode_instr_out  out  XLEN  instruction of the head entry.
- count_out  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH-entry circular buffer of {pc, instr}. head_ptr and tail_ptr are $clog2(DEPTH) bits each and wrap from DEPTH-1 to 0. The separate count register resolves full versus empty.
- Enqueue fires when fetch_valid_in && fetch_ready_out && !flush. The entry is written at tail_ptr, and tail_ptr increments.
- Dequeue fires when decode_valid_out && decode_ready_in && !flush. head_ptr increments.
- count next value:
  - count+1 on enqueue only.
  - count-1 on dequeue only.
  - unchanged on both or neither.
- fetch_ready_out = (count != DEPTH). It depends only on registered state. No combinational path from decode_ready_in, so a full queue does not accept even if a dequeue happens the same cycle.
- decode_valid_out = (count != 0). decode_pc_out and decode_instr_out are read combinationally from the head entry.
- No bypass: an instruction enqueued into an empty queue becomes visible on decode_valid_out the following cycle.
- Flush:
  - Highest priority. head_ptr, tail_ptr and count all go to 0 on that edge.
  - A same-cycle enqueue or dequeue is ignored; the decode stage must not treat a head presented during flush as consumed.
  - Entry contents are not cleared.
- Reset (reset low, any time, asynchronous):
  - head_ptr, tail_ptr and count go to 0.
  - Outputs: fetch_ready_out=1 and count_out=0 while reset is held low; decode_valid_out=0.
  - decode_pc_out and decode_instr_out are don't-care while decode_valid_out=0; the implementation drives 0 from a reset storage array.
  - Operation resumes on the first rising edge after reset goes high.
- Entry payload is never modified after write; ordering is strictly FIFO.

## Timing
- Latency: 1 cycle from an accepted enqueue to decode_valid_out when the queue is empty.
- Throughput: 1 enqueue and 1 dequeue per cycle, sustained, when 0 < count < DEPTH.
- Full boundary: at count==DEPTH, fetch_ready_out=0 in that same cycle; fetch must hold its PC. A dequeue that cycle gives count=DEPTH-1, and ready rises the next cycle.
- Empty boundary: at count==0, decode_valid_out=0; decode_ready_in is ignored.
- Wrap-around: pointers roll over silently. Correct ordering across the wrap is required.
- Flush is visible one cycle later: after flush is asserted at edge N, decode_valid_out=0 and fetch_ready_out=1 from edge N onward. A new-path instruction enqueued at edge N+1 appears at N+2.
- All outputs are glitch-free functions of registered state, except that the head payload follows the head_ptr register.

## Test plan
- Reset/idle: hold reset low for 2 cycles, release, and drive no traffic. Required: decode_valid_out=0, fetch_ready_out=1, count_out=0 for 5 cycles.
- Fill and drain:
  - Stimulus: decode_ready_in=0; enqueue PCs 0x00,0x04,...,0x1C with instructions 0x00000013+i.
  - Required: count_out reaches 8, fetch_ready_out=0 on the ninth attempt, and the ninth instruction is not stored.
  - Then set decode_ready_in=1. Required: PCs 0x00..0x1C come out in order, one per cycle, and count_out ends at 0.
- Streaming with wrap:
  - Stimulus: continuous enqueue and dequeue for 20 instructions, PC 0x100+4i.
  - Required: output PCs in order with no gaps or duplicates; count_out holds at 1 after the first cycle; pointers wrap twice.
- Full plus simultaneous dequeue:
  - Stimulus: with count=8, assert fetch_valid_in and decode_ready_in together.
  - Required: the dequeue happens, the enqueue is refused, count=7, and fetch_ready_out=1 on the next cycle.
- Flush mid-stream:
  - Stimulus: with 5 entries queued, assert flush together with fetch_valid_in and decode_ready_in.
  - Required: count_out=0 and decode_valid_out=0 on the next cycle, and the flush-cycle instruction is dropped.
  - Then enqueue PC 0x200. Required: it is the next head, presented 1 cycle later.
- Async reset mid-operation:
  - Stimulus: with 3 entries queued, pull reset low between clock edges.
  - Required: count_out=0 and decode_valid_out=0 immediately, without waiting for clk; the next instruction enqueued after release is the head.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: decoupling FIFO between fetch and decode/rename.
// Holds {pc, instr} pairs in a circular buffer. A separate occupancy counter
// resolves full versus empty. Flush discards everything in one cycle.
// Ready/valid depend only on registered state; the head payload is read
// combinationally from the head_ptr register.
module fetch_queue #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     fetch_valid_in,
  output logic                     fetch_ready_out,
  input  logic [XLEN-1:0]          fetch_pc_in,
  input  logic [XLEN-1:0]          fetch_instr_in,
  output logic                     decode_valid_out,
  input  logic                     decode_ready_in,
  output logic [XLEN-1:0]          decode_pc_out,
  output logic [XLEN-1:0]          decode_instr_out,
  output logic [$clog2(DEPTH):0]   count_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PW-1:0]   head_ptr_r;
  logic [PW-1:0]   tail_ptr_r;
  logic [CW-1:0]   count_r;
  logic [XLEN-1:0] pc_mem_r    [DEPTH];
  logic [XLEN-1:0] instr_mem_r [DEPTH];

  logic            enq_s;
  logic            deq_s;
  logic [PW-1:0]   head_nxt_s;
  logic [PW-1:0]   tail_nxt_s;
  logic [CW-1:0]   count_nxt_s;

  // Handshake status, derived from registered occupancy only.
  assign fetch_ready_out  = (count_r != DEPTH_C);
  assign decode_valid_out = (count_r != {CW{1'b0}});
  assign count_out        = count_r;
  assign decode_pc_out    = pc_mem_r[head_ptr_r];
  assign decode_instr_out = instr_mem_r[head_ptr_r];

  // Transfer qualification: flush suppresses both sides of the queue.
  assign enq_s = fetch_valid_in && fetch_ready_out && !flush;
  assign deq_s = decode_valid_out && decode_ready_in && !flush;

  // Next-state for pointers and occupancy; flush wins over any transfer.
  always_comb begin
    head_nxt_s  = head_ptr_r;
    tail_nxt_s  = tail_ptr_r;
    count_nxt_s = count_r;
    if (flush) begin
      head_nxt_s  = {PW{1'b0}};
      tail_nxt_s  = {PW{1'b0}};
      count_nxt_s = {CW{1'b0}};
    end else begin
      if (enq_s) begin
        tail_nxt_s = tail_ptr_r + PW'(1);
      end else begin
        tail_nxt_s = tail_ptr_r;
      end
      if (deq_s) begin
        head_nxt_s = head_ptr_r + PW'(1);
      end else begin
        head_nxt_s = head_ptr_r;
      end
      case ({enq_s, deq_s})
        2'b10:   count_nxt_s = count_r + CW'(1);
        2'b01:   count_nxt_s = count_r - CW'(1);
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_ptr_r <= {PW{1'b0}};
      tail_ptr_r <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
    end else begin
      head_ptr_r <= head_nxt_s;
      tail_ptr_r <= tail_nxt_s;
      count_r    <= count_nxt_s;
    end
  end

  // Entry storage: written once at the tail, never cleared by flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_r[i]    <= {XLEN{1'b0}};
        instr_mem_r[i] <= {XLEN{1'b0}};
      end
    end else if (enq_s) begin
      pc_mem_r[tail_ptr_r]    <= fetch_pc_in;
      instr_mem_r[tail_ptr_r] <= fetch_instr_in;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=8, XLEN=32).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_fetch_queue;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        fetch_valid_in;
  logic        fetch_ready_out;
  logic [31:0] fetch_pc_in;
  logic [31:0] fetch_instr_in;
  logic        decode_valid_out;
  logic        decode_ready_in;
  logic [31:0] decode_pc_out;
  logic [31:0] decode_instr_out;
  logic [3:0]  count_out;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_queue #(.DEPTH(8), .XLEN(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .flush            (flush),
    .fetch_valid_in   (fetch_valid_in),
    .fetch_ready_out  (fetch_ready_out),
    .fetch_pc_in      (fetch_pc_in),
    .fetch_instr_in   (fetch_instr_in),
    .decode_valid_out (decode_valid_out),
    .decode_ready_in  (decode_ready_in),
    .decode_pc_out    (decode_pc_out),
    .decode_instr_out (decode_instr_out),
    .count_out        (count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push one entry with decode stalled.
  task automatic push(input logic [31:0] pc, input logic [31:0] instr);
    fetch_valid_in = 1'b1;
    fetch_pc_in    = pc;
    fetch_instr_in = instr;
    tick();
    fetch_valid_in = 1'b0;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; fetch_valid_in = 1'b0; decode_ready_in = 1'b0;
    fetch_pc_in = 32'h0; fetch_instr_in = 32'h0;

    // Reset held for two cycles, then idle.
    tick();
    tick();
    check("rst_ready", 32'(fetch_ready_out), 32'd1);
    check("rst_valid", 32'(decode_valid_out), 32'd0);
    check("rst_count", 32'(count_out), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_valid", 32'(decode_valid_out), 32'd0);
      check("idle_ready", 32'(fetch_ready_out), 32'd1);
      check("idle_count", 32'(count_out), 32'd0);
    end

    // Fill to full with decode stalled.
    for (int i = 0; i < 8; i++) begin
      check("fill_ready", 32'(fetch_ready_out), 32'd1);
      push(32'(4 * i), 32'h13 + 32'(i));
      check("fill_count", 32'(count_out), 32'(i + 1));
    end
    check("full_ready", 32'(fetch_ready_out), 32'd0);
    push(32'h20, 32'h1b);
    check("full_ninth_count", 32'(count_out), 32'd8);

    // Drain in order, one per cycle.
    decode_ready_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", 32'(decode_valid_out), 32'd1);
      check("drain_pc", decode_pc_out, 32'(4 * i));
      check("drain_instr", decode_instr_out, 32'h13 + 32'(i));
      tick();
    end
    check("drain_count", 32'(count_out), 32'd0);
    check("drain_valid_end", 32'(decode_valid_out), 32'd0);

    // Streaming with wrap: enqueue and dequeue every cycle.
    fetch_valid_in = 1'b1;
    fetch_pc_in    = 32'h100;
    fetch_instr_in = 32'hA000;
    tick();
    for (int i = 1; i < 20; i++) begin
      check("stream_count", 32'(count_out), 32'd1);
      check("stream_pc", decode_pc_out, 32'h100 + 32'(4 * (i - 1)));
      fetch_pc_in    = 32'h100 + 32'(4 * i);
      fetch_instr_in = 32'hA000 + 32'(i);
      tick();
    end
    fetch_valid_in = 1'b0;
    check("stream_last_pc", decode_pc_out, 32'h14C);
    check("stream_last_instr", decode_instr_out, 32'hA013);
    tick();
    check("stream_end_count", 32'(count_out), 32'd0);

    // Full plus simultaneous dequeue: enqueue is refused.
    decode_ready_in = 1'b0;
    for (int i = 0; i < 8; i++) push(32'h300 + 32'(4 * i), 32'hB000 + 32'(i));
    check("fd_full_count", 32'(count_out), 32'd8);
    fetch_valid_in  = 1'b1;
    fetch_pc_in     = 32'h400;
    fetch_instr_in  = 32'hDEAD;
    decode_ready_in = 1'b1;
    check("fd_ready_full", 32'(fetch_ready_out), 32'd0);
    tick();
    fetch_valid_in = 1'b0;
    check("fd_count", 32'(count_out), 32'd7);
    check("fd_ready_next", 32'(fetch_ready_out), 32'd1);
    for (int i = 1; i < 8; i++) begin
      check("fd_drain_pc", decode_pc_out, 32'h300 + 32'(4 * i));
      tick();
    end
    check("fd_drain_count", 32'(count_out), 32'd0);

    // Flush mid-stream with both handshakes asserted.
    decode_ready_in = 1'b0;
    for (int i = 0; i < 5; i++) push(32'h500 + 32'(4 * i), 32'hC000 + 32'(i));
    check("fl_pre_count", 32'(count_out), 32'd5);
    flush = 1'b1; fetch_valid_in = 1'b1; decode_ready_in = 1'b1;
    fetch_pc_in = 32'h600; fetch_instr_in = 32'hBAD0;
    tick();
    flush = 1'b0; fetch_valid_in = 1'b0; decode_ready_in = 1'b0;
    check("fl_count", 32'(count_out), 32'd0);
    check("fl_valid", 32'(decode_valid_out), 32'd0);
    check("fl_ready", 32'(fetch_ready_out), 32'd1);
    push(32'h200, 32'h77);
    check("fl_new_valid", 32'(decode_valid_out), 32'd1);
    check("fl_new_pc", decode_pc_out, 32'h200);
    check("fl_new_instr", decode_instr_out, 32'h77);
    check("fl_new_count", 32'(count_out), 32'd1);
    decode_ready_in = 1'b1;
    tick();
    decode_ready_in = 1'b0;
    check("fl_after_count", 32'(count_out), 32'd0);

    // Asynchronous reset between clock edges.
    for (int i = 0; i < 3; i++) push(32'h700 + 32'(4 * i), 32'hE000 + 32'(i));
    check("ar_pre_count", 32'(count_out), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    check("ar_count", 32'(count_out), 32'd0);
    check("ar_valid", 32'(decode_valid_out), 32'd0);
    check("ar_ready", 32'(fetch_ready_out), 32'd1);
    check("ar_pc_zero", decode_pc_out, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    push(32'h800, 32'h99);
    check("ar_head_pc", decode_pc_out, 32'h800);
    check("ar_head_count", 32'(count_out), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
